// File: rtl/riscv_result_checker.sv
// Result checker / performance monitor: captures core stores into a result window,
// compares them against a golden table after the run ends and freezes the counters.
module riscv_result_checker #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int WIN_BASE   = 128,
  parameter int WIN_DEPTH  = 8,
  parameter int END_ADDR   = 255,
  parameter int CNT_W      = 16,
  parameter int ERR_W      = 8,
  parameter int TIMEOUT    = 0,
  parameter int SWAP_BYTES = 1,
  localparam int IDX_W     = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch,
  input  logic              gld_wen,
  input  logic [IDX_W-1:0]  gld_idx,
  input  logic [DATA_W-1:0] gld_data,
  output logic              finish,
  output logic              timeout,
  output logic [ERR_W-1:0]  error_num,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [CNT_W-1:0]  duration,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_times,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  instr_count,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_CMP = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cap_q  [WIN_DEPTH];
  logic [DATA_W-1:0] gold_q [WIN_DEPTH];
  logic [IDX_W-1:0]  cmp_idx_q, first_err_q;
  logic [ERR_W-1:0]  error_q;
  logic              finish_q, timeout_q;
  logic [CNT_W-1:0]  duration_q, stall_cnt_q, flush_cnt_q, branch_cnt_q, instr_cnt_q;
  logic [ADDR_W-1:0] prev_iaddr_q;

  logic [ADDR_W-1:0] win_off;
  logic              win_hit, end_hit, to_hit, gld_ok, cmp_last, cmp_mis;
  logic [DATA_W-1:0] cap_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    win_off  = addr - ADDR_W'(WIN_BASE);
    win_hit  = wen && (addr >= ADDR_W'(WIN_BASE)) && (win_off < ADDR_W'(WIN_DEPTH));
    end_hit  = wen && (addr == ADDR_W'(END_ADDR));
    to_hit   = (TIMEOUT != 0) && (duration_q == CNT_W'(TIMEOUT - 1));
    gld_ok   = gld_wen && (32'(gld_idx) < 32'(WIN_DEPTH));
    cmp_last = (cmp_idx_q == IDX_W'(WIN_DEPTH - 1));
    cmp_mis  = (cap_q[cmp_idx_q] != gold_q[cmp_idx_q]);
    // Core stores little-endian words; the golden table is in readable order.
    cap_data = data;
    if (SWAP_BYTES != 0) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        cap_data[8*b +: 8] = data[DATA_W-8-8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (end_hit || to_hit) state_d = S_CMP;
      S_CMP:   if (cmp_last) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        cap_q[i]  <= '0;
        gold_q[i] <= '0;
      end
      cmp_idx_q    <= '0;
      first_err_q  <= '0;
      error_q      <= '0;
      finish_q     <= 1'b0;
      timeout_q    <= 1'b0;
      duration_q   <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      branch_cnt_q <= '0;
      instr_cnt_q  <= '0;
      prev_iaddr_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_iaddr_q <= I_addr;
      if (gld_ok && (state_q != S_CMP)) gold_q[gld_idx] <= gld_data;
      if (state_q == S_RUN) begin
        if (win_hit) cap_q[win_off[IDX_W-1:0]] <= cap_data;
        // An end write on the timeout edge wins, so the run is not flagged as timed out.
        if (to_hit && !end_hit) timeout_q <= 1'b1;
        duration_q <= sat_inc(duration_q);
        if (stall)  stall_cnt_q  <= sat_inc(stall_cnt_q);
        if (flush)  flush_cnt_q  <= sat_inc(flush_cnt_q);
        if (branch) branch_cnt_q <= sat_inc(branch_cnt_q);
        if (I_addr != prev_iaddr_q) instr_cnt_q <= sat_inc(instr_cnt_q);
      end
      if (state_q == S_CMP) begin
        if (cmp_mis) begin
          if (error_q != '1) error_q <= error_q + 1'b1;
          if (error_q == '0) first_err_q <= cmp_idx_q;
        end
        if (cmp_last) finish_q <= 1'b1;
        else          cmp_idx_q <= cmp_idx_q + 1'b1;
      end
    end
  end

  assign finish        = finish_q;
  assign timeout       = timeout_q;
  assign error_num     = error_q;
  assign first_err_idx = first_err_q;
  assign duration      = duration_q;
  assign stall_cycles  = stall_cnt_q;
  assign flush_times   = flush_cnt_q;
  assign branch_count  = branch_cnt_q;
  assign instr_count   = instr_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_riscv_result_checker.sv
// Directed bench for riscv_result_checker: default, no-swap and timeout instances share stimulus.
module tb_riscv_result_checker;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int CW = 16;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wen = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [AW-1:0] i_addr = '0;
  logic          stall = 1'b0, flush = 1'b0, branch = 1'b0;
  logic          gld_wen = 1'b0;
  logic [IW-1:0] gld_idx = '0;
  logic [DW-1:0] gld_data = '0;

  logic          m_fin, m_to, n_fin, n_to, t_fin, t_to;
  logic [EW-1:0] m_err, n_err, t_err;
  logic [IW-1:0] m_first, n_first, t_first;
  logic [CW-1:0] m_dur, m_stall, m_flush, m_branch, m_instr;
  logic [CW-1:0] n_dur, n_stall, n_flush, n_branch, n_instr;
  logic [CW-1:0] t_dur, t_stall, t_flush, t_branch, t_instr;
  logic [1:0]    m_state, n_state, t_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_result_checker u_dut (
    .clk(clk), .rst(rst), .wen(wen), .addr(addr), .data(data), .I_addr(i_addr),
    .stall(stall), .flush(flush), .branch(branch),
    .gld_wen(gld_wen), .gld_idx(gld_idx), .gld_data(gld_data),
    .finish(m_fin), .timeout(m_to), .error_num(m_err), .first_err_idx(m_first),
    .duration(m_dur), .stall_cycles(m_stall), .flush_times(m_flush),
    .branch_count(m_branch), .instr_count(m_instr), .state_o(m_state));

  riscv_result_checker #(.SWAP_BYTES(0)) u_dut_ns (
    .clk(clk), .rst(rst), .wen(wen), .addr(addr), .data(data), .I_addr(i_addr),
    .stall(stall), .flush(flush), .branch(branch),
    .gld_wen(gld_wen), .gld_idx(gld_idx), .gld_data(gld_data),
    .finish(n_fin), .timeout(n_to), .error_num(n_err), .first_err_idx(n_first),
    .duration(n_dur), .stall_cycles(n_stall), .flush_times(n_flush),
    .branch_count(n_branch), .instr_count(n_instr), .state_o(n_state));

  riscv_result_checker #(.TIMEOUT(100)) u_dut_to (
    .clk(clk), .rst(rst), .wen(wen), .addr(addr), .data(data), .I_addr(i_addr),
    .stall(stall), .flush(flush), .branch(branch),
    .gld_wen(gld_wen), .gld_idx(gld_idx), .gld_data(gld_data),
    .finish(t_fin), .timeout(t_to), .error_num(t_err), .first_err_idx(t_first),
    .duration(t_dur), .stall_cycles(t_stall), .flush_times(t_flush),
    .branch_count(t_branch), .instr_count(t_instr), .state_o(t_state));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic fin_of(input int sel);
    case (sel)
      0:       return m_fin;
      1:       return n_fin;
      default: return t_fin;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input int a, input logic [31:0] d);
    wen = 1'b1; addr = AW'(a); data = d;
    step();
    wen = 1'b0; addr = '0; data = '0;
  endtask

  task automatic gold_write(input int idx, input logic [31:0] d);
    gld_wen = 1'b1; gld_idx = IW'(idx); gld_data = d;
    step();
    gld_wen = 1'b0; gld_idx = '0; gld_data = '0;
  endtask

  // Asserts reset off-edge, checks that outputs clear immediately, releases on a falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    wen = 1'b0; stall = 1'b0; flush = 1'b0; branch = 1'b0; gld_wen = 1'b0; i_addr = '0;
    #1;
    check_val({tag, "_finish"},  32'(m_fin),    0);
    check_val({tag, "_timeout"}, 32'(t_to),     0);
    check_val({tag, "_err"},     32'(m_err),    0);
    check_val({tag, "_first"},   32'(m_first),  0);
    check_val({tag, "_dur"},     32'(m_dur),    0);
    check_val({tag, "_stall"},   32'(m_stall),  0);
    check_val({tag, "_instr"},   32'(m_instr),  0);
    check_val({tag, "_state"},   32'(m_state),  0);
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_finish(input int sel, input int exp_lat, input string tag);
    int cnt;
    cnt = 0;
    while (!fin_of(sel) && cnt < 64) begin
      step();
      cnt++;
    end
    check_val(tag, 32'(cnt), 32'(exp_lat));
  endtask

  task automatic load_gold_seq();
    for (int i = 0; i < 8; i++) gold_write(i, 32'(i + 1));
  endtask

  task automatic pass_run(input string tag);
    load_gold_seq();
    for (int i = 0; i < 8; i++) core_write(128 + i, bswap(32'(i + 1)));
    core_write(255, 32'h0);
    wait_finish(0, 8, {tag, "_latency"});
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd0);
    check_val({tag, "_err_main"}, 32'(m_err), exp_q.pop_front());
    check_val({tag, "_err_noswap"}, 32'(n_err), exp_q.pop_front());
    check_val({tag, "_timeout"}, 32'(m_to), exp_q.pop_front());
    check_val({tag, "_first_noswap"}, 32'(n_first), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset("por");

    // Pass run, and results held in DONE.
    pass_run("pass");
    repeat (5) step();
    check_val("pass_hold_finish", 32'(m_fin), 1);
    check_val("pass_hold_state", 32'(m_state), 2);

    // Mismatches at 2 and 5, overwrite of entry 0, writes just outside the window.
    do_reset("rst_mm");
    load_gold_seq();
    core_write(128, 32'hdeadbeef);
    for (int i = 0; i < 8; i++)
      core_write(128 + i, (i == 2 || i == 5) ? 32'h63 : bswap(32'(i + 1)));
    core_write(127, 32'h11223344);
    core_write(136, 32'h55667788);
    core_write(140, 32'h99aabbcc);
    core_write(255, 32'h0);
    wait_finish(0, 8, "mm_latency");
    check_val("mm_err", 32'(m_err), 2);
    check_val("mm_first", 32'(m_first), 2);

    // Byte order: entry 0 golden is readable 1, entry 1 golden is 0x01000000.
    do_reset("rst_bo");
    gold_write(0, 32'h1);
    gold_write(1, 32'h0100_0000);
    core_write(128, 32'h0100_0000);
    core_write(129, 32'h0100_0000);
    core_write(255, 32'h0);
    wait_finish(1, 8, "bo_latency");
    check_val("bo_err_swap", 32'(m_err), 1);
    check_val("bo_first_swap", 32'(m_first), 1);
    check_val("bo_err_noswap", 32'(n_err), 1);
    check_val("bo_first_noswap", 32'(n_first), 0);

    // Counters over 20 RUN edges, the last one being the end write.
    do_reset("rst_cnt");
    for (int c = 0; c < 20; c++) begin
      stall  = (c >= 2 && c < 7);
      flush  = (c == 3 || c == 10);
      branch = (c == 4 || c == 8 || c == 12);
      i_addr = (c < 6) ? AW'(c + 1) : AW'(6);
      wen    = (c == 19);
      addr   = (c == 19) ? AW'(255) : AW'(0);
      step();
    end
    wen = 1'b0; addr = '0;
    stall = 1'b1; flush = 1'b1; branch = 1'b1; i_addr = AW'(99);
    check_val("cnt_dur", 32'(m_dur), 20);
    check_val("cnt_stall", 32'(m_stall), 5);
    check_val("cnt_flush", 32'(m_flush), 2);
    check_val("cnt_branch", 32'(m_branch), 3);
    check_val("cnt_instr", 32'(m_instr), 6);
    wait_finish(0, 8, "cnt_latency");
    for (int i = 0; i < 5; i++) begin
      i_addr = AW'(200 + i);
      step();
    end
    check_val("cnt_frz_dur", 32'(m_dur), 20);
    check_val("cnt_frz_stall", 32'(m_stall), 5);
    check_val("cnt_frz_flush", 32'(m_flush), 2);
    check_val("cnt_frz_branch", 32'(m_branch), 3);
    check_val("cnt_frz_instr", 32'(m_instr), 6);
    stall = 1'b0; flush = 1'b0; branch = 1'b0;

    // Timeout after 100 RUN edges with no end write.
    do_reset("rst_to");
    repeat (99) step();
    check_val("to_pre_timeout", 32'(t_to), 0);
    check_val("to_pre_state", 32'(t_state), 0);
    step();
    check_val("to_timeout", 32'(t_to), 1);
    check_val("to_state_cmp", 32'(t_state), 1);
    wait_finish(2, 8, "to_latency");
    check_val("to_dur", 32'(t_dur), 100);
    check_val("to_main_no_timeout", 32'(m_to), 0);
    check_val("to_main_running", 32'(m_state), 0);

    // End write on the timeout edge takes priority.
    do_reset("rst_to2");
    repeat (99) step();
    core_write(255, 32'h0);
    check_val("to2_timeout", 32'(t_to), 0);
    wait_finish(2, 8, "to2_latency");
    check_val("to2_dur", 32'(t_dur), 100);
    check_val("to2_timeout_done", 32'(t_to), 0);

    // Reset in the middle of the compare, then a fresh pass run.
    do_reset("rst_mc0");
    load_gold_seq();
    for (int i = 0; i < 8; i++) core_write(128 + i, (i == 6) ? 32'h0 : bswap(32'(i + 1)));
    core_write(255, 32'h0);
    repeat (3) step();
    check_val("mc_state_cmp", 32'(m_state), 1);
    do_reset("rst_mc");
    pass_run("repass");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_result_checker.md
# riscv_result_checker

Synthesizable, parametrised result checker and performance monitor for the RISC-V core benches. It snoops the core's data-memory write port and captures stores that fall inside a configurable result window. When the core writes the end-marker address, or when a timeout expires, it compares the captured window against golden values one entry per cycle. It then raises `finish` with the error count and the cycle, stall, flush, branch and instruction counters frozen for the bench to read.

## Interface
- `ADDR_W`, 30: word-address width of `addr` and `I_addr`.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `WIN_BASE`, 128: first word address of the result window.
- `WIN_DEPTH`, 8: number of window entries; ≥1.
- `END_ADDR`, 255: a write to this address ends the run.
- `CNT_W`, 16: width of all performance counters.
- `ERR_W`, 8: width of `error_num`.
- `TIMEOUT`, 0: run cycle limit; 0 disables the timeout.
- `SWAP_BYTES`, 1: 1 = byte-reverse write data before capture (little-endian to readable).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wen`  in  1  core data-memory write enable.
- `addr`  in  ADDR_W  core data-memory word address.
- `data`  in  DATA_W  core write data.
- `I_addr`  in  ADDR_W  core instruction fetch address.
- `stall`  in  1  core memory stall this cycle.
- `flush`  in  1  pipeline flush this cycle.
- `branch`  in  1  branch instruction resolved this cycle.
- `gld_wen`  in  1  golden-table write strobe.
- `gld_idx`  in  clog2(WIN_DEPTH)  golden entry index.
- `gld_data`  in  DATA_W  golden value, already in readable byte order.
- `finish`  out  1  check complete; results valid.
- `timeout`  out  1  the run ended by timeout, not by an END_ADDR write.
- `error_num`  out  ERR_W  number of mismatching entries; saturating.
- `first_err_idx`  out  clog2(WIN_DEPTH)  index of the lowest mismatching entry; valid only when `error_num` != 0.
- `duration`, `stall_cycles`, `flush_times`, `branch_count`, `instr_count`  out  CNT_W each  performance counters.

## Operation
- States: RUN → CMP → DONE. Reset enters RUN; there is no idle state.
- Reset (`rst`=0, asynchronous, any state, including mid-CMP):
  - State goes to RUN.
  - All capture entries, golden entries, counters, `error_num`, `first_err_idx` and the compare index clear to 0.
  - `finish`=0 and `timeout`=0.
  - The previous-I_addr register clears to 0.
- RUN capture:
  - If `wen` and WIN_BASE ≤ `addr` < WIN_BASE+WIN_DEPTH, then cap[`addr`−WIN_BASE] ← (SWAP_BYTES ? byte-reversed `data` : `data`).
  - Writes outside the window are ignored.
  - When the same entry is written more than once, the last write wins.
- RUN end:
  - `wen` with `addr`==END_ADDR moves the state to CMP at that edge.
  - If END_ADDR is inside the window, that write is also captured.
- RUN timeout: if TIMEOUT≠0 and `duration`==TIMEOUT−1 at an edge, the state moves to CMP and `timeout` is set to 1. An END_ADDR write on the same edge takes priority, and `timeout` stays 0.
- Counters are active in RUN only and freeze in CMP and DONE. All counters saturate at 2^CNT_W−1.
  - `duration` +1 every RUN cycle.
  - `stall_cycles` +1 when `stall`=1.
  - `flush_times` +1 when `flush`=1.
  - `branch_count` +1 when `branch`=1.
  - `instr_count` +1 when `I_addr` ≠ the registered previous `I_addr`. The previous-I_addr register updates every cycle.
- Golden load: `gld_wen` writes gold[`gld_idx`] in RUN and DONE. It is ignored in CMP and when `gld_idx` ≥ WIN_DEPTH.
- CMP:
  - The compare index k runs from 0 to WIN_DEPTH−1, one entry per cycle.
  - If cap[k] ≠ gold[k], `error_num` increments (saturating at 2^ERR_W−1). On the first mismatch, `first_err_idx` is set to k.
  - After k=WIN_DEPTH−1 is checked, the state moves to DONE.
  - Core writes are ignored in CMP.
- DONE: `finish`=1. All result outputs hold until reset. Core writes are ignored.

## Timing
- All outputs are registered.
- An END_ADDR write sampled at edge N gives CMP for edges N+1 … N+WIN_DEPTH, and `finish`=1 from edge N+WIN_DEPTH onward (visible after that edge).
- Latency from end write to `finish` is WIN_DEPTH cycles.
- `error_num` may update during CMP. The bench reads it only when `finish`=1.
- A window write on the same edge as the END_ADDR write is captured before the compare starts.
- A golden write and a compare of the same entry never coincide, because golden writes are blocked in CMP.

## Test plan
- Pass run (defaults): load gold = 1..8, write 1..8 (byte-swapped on `data`) to addresses 128..135, then write to 255 → `finish` rises 8 cycles later, `error_num`=0, `timeout`=0.
- Mismatch: same as the pass run but write 0x63 to addresses 130 and 133 → `error_num`=2, `first_err_idx`=2. A write to address 140 (out of window) changes nothing.
- Byte order: SWAP_BYTES=1, `data`=0x01000000 at address 128 → cap[0]=0x00000001. With SWAP_BYTES=0 → cap[0]=0x01000000.
- Counters: 20 RUN cycles with `stall` high for 5, `flush` pulses ×2, `branch` ×3, and `I_addr` stepping 1..6 then holding, then the end write → `duration`=20, `stall_cycles`=5, `flush_times`=2, `branch_count`=3, `instr_count`=6. All counters stay frozen afterwards.
- Timeout: TIMEOUT=100, no END_ADDR write → CMP entered after 100 RUN cycles, `timeout`=1, `finish` 8 cycles later, `duration`=100. Repeat with the end write on the timeout edge → `timeout`=0.
- Reset mid-CMP: assert `rst`=0 at CMP index 3 → all outputs 0 immediately. After release, a new pass run behaves exactly like the pass-run scenario.
